fft_spectrum_reader: RTL and testbench

- Read-side companion to fft_top.
- On each fft_done it sweeps the FFT output RAM through fft_addr_out/fft_data_out_en and absorbs the fixed RAM read latency.
- It streams bin magnitudes downstream (HDMI spectrum renderer) on a valid/ready interface with a small skid buffer.
- It reports the two largest bins per frame.

---
 rtl/fft_spectrum_reader.sv | 170 +++++++++++++++++
 tb/tb_fft_spectrum_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_reader.sv
// Sweeps the FFT output RAM after each fft_done edge, streams bin magnitudes
// through a credit-protected skid buffer and reports the two largest bins.
module fft_spectrum_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int BINS       = 128,
    parameter int RD_LAT     = 2,
    parameter int MIN_BIN    = 1,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_done,
    output logic                  fft_data_out_en,
    output logic [ADDR_WIDTH-1:0] fft_addr_out,
    input  logic [DATA_WIDTH-1:0] fft_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_bin,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] peak1_bin,
    output logic [ADDR_WIDTH-1:0] peak2_bin,
    output logic [DATA_WIDTH-1:0] peak1_mag,
    output logic [DATA_WIDTH-1:0] peak2_mag,
    output logic                  peaks_valid,
    output logic                  busy,
    output logic                  overrun
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(BINS - 1);
    localparam logic [ADDR_WIDTH-1:0] MIN_ADDR = ADDR_WIDTH'(MIN_BIN);
    localparam logic [PW-1:0]         PTR_MAX  = PW'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_next;

    // Stream handshake: a beat transfers on a rising clk edge where m_valid and
    // m_ready are both high; m_valid never drops and the head never changes
    // until that transfer happens.
    logic                  done_q;
    logic                  start_edge;
    logic                  issue;
    logic                  pop;
    logic                  push;
    logic                  frame_end;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CW-1:0]         credit;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
    logic [RD_LAT-1:0]     dl_valid;
    logic [ADDR_WIDTH-1:0] dl_addr [RD_LAT];
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [ADDR_WIDTH-1:0] w1_bin, w2_bin;
    logic [DATA_WIDTH-1:0] w1_mag, w2_mag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign start_edge = fft_done & ~done_q;
    assign head       = mem[rd_ptr];
    assign m_valid    = (count != '0);
    assign m_data     = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_bin      = m_valid ? head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign m_last     = m_valid && (m_bin == LAST_BIN);
    assign pop        = m_valid & m_ready;
    assign push       = dl_valid[RD_LAT-1];
    assign push_addr  = dl_addr[RD_LAT-1];
    assign frame_end  = (state == DRAIN) && pop && m_last;

    assign fft_data_out_en = issue;
    assign fft_addr_out    = rd_addr;
    assign peaks_valid     = (state == DONE);
    assign busy            = (state != IDLE);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:  if (start_edge) state_next = READ;
            READ: begin
                issue = (credit != '0);
                if (issue && rd_addr == LAST_BIN) state_next = DRAIN;
            end
            DRAIN: if (frame_end) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Credits count free buffer slots minus reads still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            rd_addr <= '0;
            credit  <= CW'(BUF_DEPTH);
            overrun <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= fft_done;
            if (state == IDLE && start_edge) rd_addr <= '0;
            else if (issue)                  rd_addr <= rd_addr + 1'b1;
            credit <= credit - CW'(issue) + CW'(pop);
            if (start_edge && state != IDLE) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) dl_addr[i] <= '0;
        end else begin
            dl_valid[0] <= issue;
            dl_addr[0]  <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_addr[i]  <= dl_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_addr, fft_data_out};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Strict compares keep the earlier bin on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1_bin <= '0; w1_mag <= '0; w2_bin <= '0; w2_mag <= '0;
        end else if (state == IDLE && start_edge) begin
            w1_bin <= '0; w1_mag <= '0; w2_bin <= '0; w2_mag <= '0;
        end else if (push && push_addr >= MIN_ADDR) begin
            if (fft_data_out > w1_mag) begin
                w2_bin <= w1_bin;
                w2_mag <= w1_mag;
                w1_bin <= push_addr;
                w1_mag <= fft_data_out;
            end else if (fft_data_out > w2_mag) begin
                w2_bin <= push_addr;
                w2_mag <= fft_data_out;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak1_bin <= '0; peak1_mag <= '0; peak2_bin <= '0; peak2_mag <= '0;
        end else if (frame_end) begin
            peak1_bin <= w1_bin; peak1_mag <= w1_mag;
            peak2_bin <= w2_bin; peak2_mag <= w2_mag;
        end
    end
endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Randomized scoreboard bench for fft_spectrum_reader with a RAM latency model.
module tb_fft_spectrum_reader;
    localparam int DW = 12, AW = 8, BINS = 128, RD_LAT = 2, MIN_BIN = 1, BUF_DEPTH = 4;

    logic clk = 1'b0, rst = 1'b1, fft_done = 1'b0, m_ready = 1'b1;
    logic fft_data_out_en, m_valid, m_last, peaks_valid, busy, overrun;
    logic [AW-1:0] fft_addr_out, m_bin, peak1_bin, peak2_bin;
    logic [DW-1:0] fft_data_out, m_data, peak1_mag, peak2_mag;

    fft_spectrum_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BINS(BINS), .RD_LAT(RD_LAT),
                          .MIN_BIN(MIN_BIN), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .rst(rst), .fft_done(fft_done), .fft_data_out_en(fft_data_out_en),
        .fft_addr_out(fft_addr_out), .fft_data_out(fft_data_out), .m_data(m_data),
        .m_bin(m_bin), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .peak1_bin(peak1_bin), .peak2_bin(peak2_bin), .peak1_mag(peak1_mag),
        .peak2_mag(peak2_mag), .peaks_valid(peaks_valid), .busy(busy), .overrun(overrun));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data for an address appears RD_LAT cycles after it is presented.
    logic [DW-1:0] ram [BINS];
    logic [AW-1:0] apipe [RD_LAT];
    always @(posedge clk) begin
        apipe[0] <= fft_addr_out;
        for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign fft_data_out = ram[apipe[RD_LAT-1]];

    int n_vec = 0, n_err = 0;
    logic [AW+DW-1:0]       exp_q[$];
    logic [2*(AW+DW)-1:0]   exp_pk_q[$];
    int ready_mode = 0, ready_start = 0, pv_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ((cyc - ready_start) % 4 == 0) &&
                         !((cyc - ready_start) >= 200 && (cyc - ready_start) < 250);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference: stream is every bin in address order; peaks are the largest
    // eligible magnitude (earliest bin on ties) and the largest of the rest.
    task automatic model_frame();
        int b1, m1, b2, m2;
        for (int b = 0; b < BINS; b++) exp_q.push_back({AW'(b), ram[b]});
        b1 = 0; m1 = 0; b2 = 0; m2 = 0;
        for (int b = MIN_BIN; b < BINS; b++)
            if (int'(ram[b]) > m1) begin m1 = ram[b]; b1 = b; end
        for (int b = MIN_BIN; b < BINS; b++)
            if (b != b1 && int'(ram[b]) > m2) begin m2 = ram[b]; b2 = b; end
        exp_pk_q.push_back({AW'(b1), DW'(m1), AW'(b2), DW'(m2)});
    endtask

    // Monitor
    int n_strobe = 0, outstanding = 0, first_strobe_cyc = 0, last_strobe_cyc = 0;
    bit first_v_seen = 0, pv_pending = 0, stalled_prev = 0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_bin;
    always @(negedge clk) begin
        if (rst) begin
            n_strobe = 0; outstanding = 0; first_v_seen = 0; pv_pending = 0; stalled_prev = 0;
        end else begin
            if (fft_data_out_en) begin
                if (n_strobe == 0) first_strobe_cyc = cyc;
                last_strobe_cyc = cyc;
                chk("strobe_addr", fft_addr_out, n_strobe);
                n_strobe++;
            end
            outstanding = outstanding + int'(fft_data_out_en) - int'(m_valid && m_ready);
            chk("outstanding_le_depth", int'(outstanding <= BUF_DEPTH), 1);
            if (m_valid && !first_v_seen && n_strobe > 0) begin
                first_v_seen = 1;
                chk("first_valid_latency", cyc - first_strobe_cyc, RD_LAT + 1);
            end
            if (stalled_prev) begin
                chk("stall_valid_held", m_valid, 1);
                chk("stall_data_held", m_data, prev_data);
                chk("stall_bin_held", m_bin, prev_bin);
            end
            stalled_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_bin = m_bin;
            if (pv_pending) begin
                chk("peaks_valid_after_last", peaks_valid, 1);
                pv_pending = 0;
            end
            if (peaks_valid) begin
                pv_count++;
                if (exp_pk_q.size() == 0) chk("unexpected_peaks_valid", 1, 0);
                else begin
                    logic [2*(AW+DW)-1:0] e;
                    e = exp_pk_q.pop_front();
                    chk("peak1_bin", peak1_bin, e[2*(AW+DW)-1 -: AW]);
                    chk("peak1_mag", peak1_mag, e[AW+2*DW-1 -: DW]);
                    chk("peak2_bin", peak2_bin, e[AW+DW-1 -: AW]);
                    chk("peak2_mag", peak2_mag, e[DW-1:0]);
                end
                chk("strobes_per_frame", n_strobe, BINS);
                if (ready_mode == 0) chk("strobe_span", last_strobe_cyc - first_strobe_cyc, BINS - 1);
                n_strobe = 0;
                first_v_seen = 0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", m_bin, -1);
                else begin
                    logic [AW+DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("m_bin", m_bin, e[AW+DW-1:DW]);
                    chk("m_data", m_data, e[DW-1:0]);
                    chk("m_last", m_last, int'(e[AW+DW-1:DW] == AW'(BINS - 1)));
                    if (m_last) pv_pending = 1;
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_en", fft_data_out_en, 0);  chk("rst_addr", fft_addr_out, 0);
        chk("rst_m_valid", m_valid, 0);     chk("rst_m_data", m_data, 0);
        chk("rst_m_bin", m_bin, 0);         chk("rst_m_last", m_last, 0);
        chk("rst_p1b", peak1_bin, 0);       chk("rst_p1m", peak1_mag, 0);
        chk("rst_p2b", peak2_bin, 0);       chk("rst_p2m", peak2_mag, 0);
        chk("rst_pv", peaks_valid, 0);      chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    task automatic start_frame(input int mode);
        @(posedge clk); #1;
        ready_mode = mode;
        ready_start = cyc;
        model_frame();
        fft_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 fft_done = 1'b0;
    endtask

    task automatic wait_frame();
        int start;
        start = pv_count;
        for (int i = 0; i < 6000 && pv_count == start; i++) @(posedge clk);
        if (pv_count == start) chk("frame_timeout", 0, 1);
        repeat (3) @(posedge clk);
        chk("stream_queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_strobe_addr(input int a);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (fft_data_out_en && fft_addr_out == AW'(a)) break;
        end
        if (i == 4000) chk("wait_strobe_timeout", 0, 1);
    endtask

    initial begin
        int pv_before;
        for (int b = 0; b < BINS; b++) ram[b] = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rst = 1'b0;

        // Ramp
        for (int b = 0; b < BINS; b++) ram[b] = DW'(b);
        start_frame(0); wait_frame();

        // Two-tone, DC excluded
        for (int b = 0; b < BINS; b++) ram[b] = DW'(5);
        ram[0] = DW'(4095); ram[20] = DW'(900); ram[45] = DW'(1200);
        start_frame(0); wait_frame();
        chk("tone_p1_bin", peak1_bin, 45); chk("tone_p1_mag", peak1_mag, 1200);
        chk("tone_p2_bin", peak2_bin, 20); chk("tone_p2_mag", peak2_mag, 900);

        // Backpressure with a long stall
        for (int b = 0; b < BINS; b++) ram[b] = DW'($urandom_range(0, 4095));
        start_frame(1); wait_frame();

        // Tie
        for (int b = 0; b < BINS; b++) ram[b] = '0;
        ram[10] = DW'(800); ram[30] = DW'(800);
        start_frame(2); wait_frame();
        chk("tie_p1_bin", peak1_bin, 10); chk("tie_p2_bin", peak2_bin, 30);

        // Random frames with narrow value range to provoke ties
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < BINS; b++) ram[b] = DW'($urandom_range(0, (f == 0) ? 7 : 4095));
            start_frame(2); wait_frame();
        end

        // Overrun: second edge mid-frame is ignored
        for (int b = 0; b < BINS; b++) ram[b] = DW'($urandom_range(0, 4095));
        pv_before = pv_count;
        start_frame(0);
        wait_strobe_addr(60);
        @(posedge clk); #1 fft_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 fft_done = 1'b0;
        wait_frame();
        repeat (20) @(posedge clk);
        chk("overrun_one_pv", pv_count - pv_before, 1);
        chk("overrun_idle", busy, 0);
        chk("overrun_set", overrun, 1);
        for (int b = 0; b < BINS; b++) ram[b] = DW'($urandom_range(0, 4095));
        start_frame(0); wait_frame();
        chk("overrun_sticky", overrun, 1);

        // Reset at bin 70 with fft_done held high
        for (int b = 0; b < BINS; b++) ram[b] = DW'($urandom_range(0, 4095));
        @(posedge clk); #1;
        ready_mode = 0;
        model_frame();
        fft_done = 1'b1;
        wait_strobe_addr(70);
        @(posedge clk); #1 rst = 1'b1;
        #1 check_reset_outputs();
        exp_q.delete();
        exp_pk_q.delete();
        for (int b = 0; b < BINS; b++) ram[b] = DW'($urandom_range(0, 4095));
        model_frame();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_frame();
        fft_done = 1'b0;
        repeat (5) @(posedge clk);
        chk("post_reset_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
